// File: rtl/pow_engine.sv
// Sequential integer power unit: computes base**exp by LSB-first square-and-multiply,
// one exponent bit per cycle, with sticky overflow tracking and optional saturation.
module pow_engine #(
    parameter int W   = 3,
    parameter int EW  = 3,
    parameter int RW  = 2 * W,
    parameter bit SAT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp,
    output logic [RW-1:0] result,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t        state_q,  state_d;
    logic [RW-1:0] acc_q,    acc_d;
    logic [RW-1:0] b_q,      b_d;
    logic [EW-1:0] e_q,      e_d;
    logic          b_ovf_q,  b_ovf_d;
    logic          a_ovf_q,  a_ovf_d;
    logic [RW-1:0] result_q, result_d;
    logic          ovf_q,    ovf_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic [RW-1:0]   base_ext_s;
    logic [RW-1:0]   one_s;
    logic [2*RW-1:0] ab_prod_s;
    logic [2*RW-1:0] bb_prod_s;
    logic            ab_hi_s;
    logic            bb_hi_s;

    // Zero-extended base and constant one at result width
    always_comb begin
        base_ext_s        = '0;
        base_ext_s[W-1:0] = base;
        one_s             = '0;
        one_s[0]          = 1'b1;
    end

    // Full-width products; any bit above RW means the true product overflowed
    assign ab_prod_s = {{RW{1'b0}}, acc_q} * {{RW{1'b0}}, b_q};
    assign bb_prod_s = {{RW{1'b0}}, b_q} * {{RW{1'b0}}, b_q};
    assign ab_hi_s   = |ab_prod_s[2*RW-1:RW];
    assign bb_hi_s   = |bb_prod_s[2*RW-1:RW];

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        e_d      = e_q;
        b_ovf_d  = b_ovf_q;
        a_ovf_d  = a_ovf_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = one_s;
                    b_d     = base_ext_s;
                    e_d     = exp;
                    b_ovf_d = 1'b0;
                    a_ovf_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (e_q == '0) begin
                    result_d = (SAT && a_ovf_q) ? {RW{1'b1}} : acc_q;
                    ovf_d    = a_ovf_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    if (e_q[0]) begin
                        acc_d = ab_prod_s[RW-1:0];
                        // A wrapped nonzero square means the true operand is already too large
                        if (ab_hi_s || (b_ovf_q && (b_q != '0))) begin
                            a_ovf_d = 1'b1;
                        end else begin
                            a_ovf_d = a_ovf_q;
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                    if (bb_hi_s) begin
                        b_ovf_d = 1'b1;
                    end else begin
                        b_ovf_d = b_ovf_q;
                    end
                    b_d = bb_prod_s[RW-1:0];
                    e_d = e_q >> 1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            e_q      <= '0;
            b_ovf_q  <= 1'b0;
            a_ovf_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            e_q      <= e_d;
            b_ovf_q  <= b_ovf_d;
            a_ovf_q  <= a_ovf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_pow_engine.sv
// Self-checking bench for pow_engine: SAT=0 and SAT=1 instances share stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_pow_engine;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [2:0] base, exp_i;
    logic [5:0] res0, res1;
    logic       busy0, done0, ovf0, busy1, done1, ovf1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pow_engine #(.W(3), .EW(3), .RW(6), .SAT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .exp(exp_i),
        .result(res0), .busy(busy0), .done(done0), .ovf(ovf0));

    pow_engine #(.W(3), .EW(3), .RW(6), .SAT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .exp(exp_i),
        .result(res1), .busy(busy1), .done(done1), .ovf(ovf1));

    // {ovf, result mod 64}: result from true arithmetic, ovf from the sticky-flag rules
    function automatic logic [6:0] spec_pow(input int bb, input int ee);
        longint p   = 1;
        int     acc = 1;
        int     b   = bb;
        int     e   = ee;
        bit     bo  = 1'b0;
        bit     ao  = 1'b0;
        for (int i = 0; i < ee; i++) p = p * bb;
        while (e != 0) begin
            if (e % 2 == 1) begin
                if ((acc * b >= 64) || (bo && b != 0)) ao = 1'b1;
                acc = (acc * b) % 64;
            end
            if (b * b >= 64) bo = 1'b1;
            b = (b * b) % 64;
            e = e / 2;
        end
        return {ao, 6'(p % 64)};
    endfunction

    function automatic int spec_lat(input int ee);
        int l = 0;
        int e = ee;
        if (ee == 0) return 1;
        while (e > 1) begin
            e = e / 2;
            l++;
        end
        return l + 2;
    endfunction

    // Reference model: one transaction at a time, completion counted down in cycles
    logic       m_busy, m_done, m_ovf;
    logic [5:0] m_res0, m_res1;
    logic [6:0] m_pend;
    int         m_left;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0;
            m_res0 <= 6'd0;
            m_res1 <= 6'd0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_left <= spec_lat(int'(exp_i));
                m_pend <= spec_pow(int'(base), int'(exp_i));
            end
        end else if (abort) begin
            m_busy <= 1'b0;
        end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res0 <= m_pend[5:0];
            m_res1 <= m_pend[6] ? 6'd63 : m_pend[5:0];
            m_ovf  <= m_pend[6];
        end else begin
            m_left <= m_left - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", 32'(busy0), 32'(m_busy));
            chk("busy1", 32'(busy1), 32'(m_busy));
            chk("done0", 32'(done0), 32'(m_done));
            chk("done1", 32'(done1), 32'(m_done));
            chk("res0",  32'(res0),  32'(m_res0));
            chk("res1",  32'(res1),  32'(m_res1));
            chk("ovf0",  32'(ovf0),  32'(m_ovf));
            chk("ovf1",  32'(ovf1),  32'(m_ovf));
        end
    end

    // Called at a negedge; returns edges from accept to done, or 40 on timeout
    task automatic do_op(input logic [2:0] b, input logic [2:0] e, output int lat);
        base  = b;
        exp_i = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'(lat), 32'd0);
    endtask

    int lat;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base = 3'd0; exp_i = 3'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_res", 32'(res0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'd2, 3'd5, lat);
        chk("2^5", 32'(res0), 32'd32);
        chk("2^5_lat", 32'(lat), 32'd4);
        do_op(3'd7, 3'd2, lat);
        chk("7^2", 32'(res0), 32'd49);
        do_op(3'd5, 3'd0, lat);
        chk("5^0", 32'(res0), 32'd1);
        chk("5^0_lat", 32'(lat), 32'd1);
        do_op(3'd3, 3'd4, lat);
        chk("3^4_sat", 32'(res1), 32'd63);
        chk("3^4_wrap", 32'(res0), 32'd17);
        chk("3^4_ovf", 32'(ovf0), 32'd1);
        do_op(3'd0, 3'd0, lat);
        chk("0^0", 32'(res0), 32'd1);
        do_op(3'd0, 3'd7, lat);
        chk("0^7", 32'(res0), 32'd0);
        chk("0^7_ovf", 32'(ovf0), 32'd0);
        chk("b2b_lat", 32'(lat), 32'd4);
        do_op(3'd3, 3'd2, lat);
        chk("3^2", 32'(res0), 32'd9);

        // abort on 2nd COMPUTE cycle, with a start pulsed while busy
        @(negedge clk);
        base = 3'd2; exp_i = 3'd5; start = 1'b1;
        @(negedge clk);
        base = 3'd7; exp_i = 3'd7;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_res", 32'(res0), 32'd9);
        repeat (3) @(negedge clk);
        chk("no_queue", 32'(busy0), 32'd0);

        // reset on 2nd COMPUTE cycle
        base = 3'd7; exp_i = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_res", 32'(res0), 32'd0);
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        do_op(3'd6, 3'd2, lat);
        chk("6^2", 32'(res0), 32'd36);

        // randomized traffic, covered by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            base  = 3'($urandom_range(0, 7));
            exp_i = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
